// File: rtl/reg_loader_pkg.sv
// rtl/reg_loader_pkg.sv - state encoding and fixed widths shared by the reg_loader files
package reg_loader_pkg;

  // Gap counter width; GAP parameter values are limited to 0..255
  localparam int GAP_CNT_W = 8;

  // Transfer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/reg_loader_if.sv
// rtl/reg_loader_if.sv - upstream word handshake plus reg_val load/readback bundle
interface reg_loader_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] reg_q;

  // Loader side: consumes upstream words, drives reg_val, reads its output back
  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output load,
    output data_in,
    input  reg_q
  );

  // Environment side: producer plus the attached reg_val
  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  load,
    input  data_in,
    output reg_q
  );

endinterface

// File: rtl/reg_val.sv
// rtl/reg_val.sv - load-enabled register used as the loader's word hold stage
module reg_val #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Capture a new word only when load is asserted, otherwise hold
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = data_in;
    end
  end

  // Storage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/reg_loader.sv
// rtl/reg_loader.sv - write-side master that loads reg_val, reads it back and counts loads
module reg_loader
  import reg_loader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_loader_if.master     bus,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] load_cnt
);

  localparam logic [GAP_CNT_W-1:0] GAP_INIT = GAP_CNT_W'(GAP);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

  state_e                 state_q, state_d;
  logic                   load_q, load_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GAP_CNT_W-1:0]   gap_q, gap_d;
  logic                   accept;
  logic [WIDTH-1:0]       hold_q;

  // A word is taken only while idle; the hold stage keeps it for load and compare
  assign accept = (state_q == ST_IDLE) && bus.in_valid;

  reg_val #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .data_in  (bus.in_data),
    .data_out (hold_q)
  );

  // Next-state, readback check, saturating load count, gap countdown
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    load_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // reg_val captured the word on the edge that ended LOAD
        if (bus.reg_q != hold_q) begin
          err_d = 1'b1;
        end
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
        if (GAP == 0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d   = GAP_INIT;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_d = gap_q - GAP_LAST;
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Registered strobe: high exactly for the cycle spent in LOAD
    load_d = (state_d == ST_LOAD);
  end

  // State and status registers; reset aborts any in-flight word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.in_ready = (state_q == ST_IDLE);
  assign bus.load     = load_q;
  assign bus.data_in  = hold_q;
  assign busy         = (state_q != ST_IDLE);
  assign err          = err_q;
  assign load_cnt     = cnt_q;

endmodule

// File: tb/tb_reg_loader.sv
// tb/tb_reg_loader.sv - self-checking bench for reg_loader with scoreboarded load data
module tb_reg_loader;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- DUT A: GAP=0, CNT_W=8 ----------------
  reg_loader_if #(.WIDTH(W)) bus_a ();
  logic         busy_a, err_a;
  logic [7:0]   cnt_a;
  logic [W-1:0] rv_a;
  logic         force_a;
  logic [W-1:0] force_val_a;

  reg_loader #(.WIDTH(W), .GAP(0), .CNT_W(8)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_a.master),
    .busy     (busy_a),
    .err      (err_a),
    .load_cnt (cnt_a)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rv_a <= '0;
    else if (bus_a.load) rv_a <= bus_a.data_in;
  end
  assign bus_a.reg_q = force_a ? force_val_a : rv_a;

  // ---------------- DUT B: GAP=2, CNT_W=8 ----------------
  reg_loader_if #(.WIDTH(W)) bus_b ();
  logic         busy_b, err_b;
  logic [7:0]   cnt_b;
  logic [W-1:0] rv_b;

  reg_loader #(.WIDTH(W), .GAP(2), .CNT_W(8)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_b.master),
    .busy     (busy_b),
    .err      (err_b),
    .load_cnt (cnt_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rv_b <= '0;
    else if (bus_b.load) rv_b <= bus_b.data_in;
  end
  assign bus_b.reg_q = rv_b;

  // ---------------- DUT C: GAP=0, CNT_W=2 ----------------
  reg_loader_if #(.WIDTH(W)) bus_c ();
  logic         busy_c, err_c;
  logic [1:0]   cnt_c;
  logic [W-1:0] rv_c;

  reg_loader #(.WIDTH(W), .GAP(0), .CNT_W(2)) dut_c (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_c.master),
    .busy     (busy_c),
    .err      (err_c),
    .load_cnt (cnt_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rv_c <= '0;
    else if (bus_c.load) rv_c <= bus_c.data_in;
  end
  assign bus_c.reg_q = rv_c;

  // ---------------- scoreboards ----------------
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  int           load_times_b[$];
  logic         prev_load_a = 1'b0;
  logic         prev_load_b = 1'b0;
  logic [W-1:0] sb_w;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus_a.load === 1'b1) begin
        tests_run++;
        if (exp_a.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_a unexpected load data_in=%h, required no load", bus_a.data_in);
        end else begin
          sb_w = exp_a.pop_front();
          if (bus_a.data_in !== sb_w) begin
            tests_failed++;
            $display("FAIL sb_a data_in=%h required=%h", bus_a.data_in, sb_w);
          end
        end
        if (prev_load_a === 1'b1) begin
          tests_failed++;
          $display("FAIL sb_a_double_load load=1 prev=1 required prev=0");
        end
      end
      if (bus_b.load === 1'b1) begin
        tests_run++;
        load_times_b.push_back(cyc);
        if (exp_b.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_b unexpected load data_in=%h, required no load", bus_b.data_in);
        end else begin
          sb_w = exp_b.pop_front();
          if (bus_b.data_in !== sb_w) begin
            tests_failed++;
            $display("FAIL sb_b data_in=%h required=%h", bus_b.data_in, sb_w);
          end
        end
        if (prev_load_b === 1'b1) begin
          tests_failed++;
          $display("FAIL sb_b_double_load load=1 prev=1 required prev=0");
        end
      end
    end
    prev_load_a = bus_a.load;
    prev_load_b = bus_b.load;
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    bus_a.in_valid = 1'b0; bus_a.in_data = '0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0;
    bus_c.in_valid = 1'b0; bus_c.in_data = '0;
    force_a = 1'b0; force_val_a = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    exp_a.delete();
    exp_b.delete();
    load_times_b.delete();
    rst_n = 1'b1;
  endtask

  // Returns 1 ns after the accepting edge
  task automatic send_a(input logic [W-1:0] w);
    int guard = 0;
    @(negedge clk);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = w;
    while (bus_a.in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      tests_run++; tests_failed++;
      $display("FAIL send_a_timeout in_ready=%b required=1", bus_a.in_ready);
    end else begin
      exp_a.push_back(w);
    end
    @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0;
  endtask

  task automatic send_c(input logic [W-1:0] w);
    int guard = 0;
    @(negedge clk);
    bus_c.in_valid = 1'b1;
    bus_c.in_data  = w;
    while (bus_c.in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      tests_run++; tests_failed++;
      $display("FAIL send_c_timeout in_ready=%b required=1", bus_c.in_ready);
    end
    @(posedge clk);
    #1;
    bus_c.in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus_a.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready_during in_ready=%b required=1", bus_a.in_ready);
    end
    do_reset();
    @(negedge clk);
    tests_run++;
    if (bus_a.load !== 1'b0) begin tests_failed++; $display("FAIL reset_load load=%b required=0", bus_a.load); end
    tests_run++;
    if (bus_a.data_in !== 8'h00) begin tests_failed++; $display("FAIL reset_data_in data_in=%h required=00", bus_a.data_in); end
    tests_run++;
    if (err_a !== 1'b0) begin tests_failed++; $display("FAIL reset_err err=%b required=0", err_a); end
    tests_run++;
    if (cnt_a !== 8'd0) begin tests_failed++; $display("FAIL reset_load_cnt load_cnt=%0d required=0", cnt_a); end
    tests_run++;
    if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL reset_busy busy=%b required=0", busy_a); end
    tests_run++;
    if (bus_a.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready in_ready=%b required=1", bus_a.in_ready); end
  endtask

  task automatic test_single_word();
    send_a(8'hA5);
    @(negedge clk);  // LOAD cycle
    tests_run++;
    if (bus_a.load !== 1'b1 || bus_a.data_in !== 8'hA5) begin
      tests_failed++; $display("FAIL single_load load=%b data_in=%h required load=1 data_in=a5", bus_a.load, bus_a.data_in);
    end
    tests_run++;
    if (busy_a !== 1'b1 || bus_a.in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL single_busy busy=%b in_ready=%b required busy=1 in_ready=0", busy_a, bus_a.in_ready);
    end
    @(negedge clk);  // CHECK cycle
    tests_run++;
    if (bus_a.load !== 1'b0 || bus_a.reg_q !== 8'hA5 || bus_a.in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL single_check load=%b reg_q=%h in_ready=%b required load=0 reg_q=a5 in_ready=0", bus_a.load, bus_a.reg_q, bus_a.in_ready);
    end
    @(negedge clk);  // back in IDLE
    tests_run++;
    if (bus_a.in_ready !== 1'b1 || busy_a !== 1'b0) begin
      tests_failed++; $display("FAIL single_ready in_ready=%b busy=%b required in_ready=1 busy=0", bus_a.in_ready, busy_a);
    end
    tests_run++;
    if (cnt_a !== 8'd1 || err_a !== 1'b0) begin
      tests_failed++; $display("FAIL single_status load_cnt=%0d err=%b required load_cnt=1 err=0", cnt_a, err_a);
    end
    tests_run++;
    if (bus_a.data_in !== 8'hA5) begin
      tests_failed++; $display("FAIL single_data_hold data_in=%h required=a5", bus_a.data_in);
    end
  endtask

  task automatic test_back_to_back_gap2();
    logic [W-1:0] words [3];
    int idx   = 0;
    int guard = 0;
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    do_reset();
    @(negedge clk);
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = words[0];
    while (idx < 3 && guard < 100) begin
      if (bus_b.in_ready === 1'b1) begin
        exp_b.push_back(bus_b.in_data);
        idx++;
        @(posedge clk);
        #1;
        if (idx < 3) bus_b.in_data = words[idx];
        else         bus_b.in_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      tests_run++; tests_failed++;
      $display("FAIL stream_timeout accepted=%0d required=3", idx);
    end
    repeat (8) @(negedge clk);
    tests_run++;
    if (load_times_b.size() != 3) begin
      tests_failed++; $display("FAIL stream_load_count loads=%0d required=3", load_times_b.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        tests_run++;
        if (load_times_b[i] - load_times_b[i-1] != 5) begin
          tests_failed++; $display("FAIL stream_spacing gap=%0d required=5", load_times_b[i] - load_times_b[i-1]);
        end
      end
    end
    tests_run++;
    if (cnt_b !== 8'd3 || err_b !== 1'b0) begin
      tests_failed++; $display("FAIL stream_status load_cnt=%0d err=%b required load_cnt=3 err=0", cnt_b, err_b);
    end
    tests_run++;
    if (exp_b.size() != 0) begin
      tests_failed++; $display("FAIL stream_leftover pending=%0d required=0", exp_b.size());
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    force_a     = 1'b1;
    force_val_a = 8'h00;
    send_a(8'h3C);
    @(negedge clk);  // LOAD
    @(negedge clk);  // CHECK
    tests_run++;
    if (err_a !== 1'b0) begin
      tests_failed++; $display("FAIL mismatch_err_early err=%b required=0", err_a);
    end
    @(negedge clk);  // cycle after CHECK
    tests_run++;
    if (err_a !== 1'b1) begin
      tests_failed++; $display("FAIL mismatch_err err=%b required=1", err_a);
    end
    force_a = 1'b0;
    send_a(8'h55);
    repeat (3) @(negedge clk);
    tests_run++;
    if (err_a !== 1'b1) begin
      tests_failed++; $display("FAIL mismatch_err_sticky err=%b required=1", err_a);
    end
    tests_run++;
    if (cnt_a !== 8'd2) begin
      tests_failed++; $display("FAIL mismatch_load_cnt load_cnt=%0d required=2", cnt_a);
    end
  endtask

  task automatic test_reset_mid_op();
    send_a(8'hFF);
    tests_run++;
    if (bus_a.load !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_load_before load=%b required=1", bus_a.load);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus_a.load !== 1'b0 || busy_a !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_async load=%b busy=%b required load=0 busy=0", bus_a.load, busy_a);
    end
    repeat (2) @(negedge clk);
    exp_a.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (cnt_a !== 8'd0 || err_a !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_status load_cnt=%0d err=%b required load_cnt=0 err=0", cnt_a, err_a);
    end
    tests_run++;
    if (bus_a.data_in !== 8'h00) begin
      tests_failed++; $display("FAIL midrst_data_in data_in=%h required=00", bus_a.data_in);
    end
    tests_run++;
    if (bus_a.in_ready !== 1'b1 || busy_a !== 1'b0 || bus_a.load !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_idle in_ready=%b busy=%b load=%b required 1 0 0", bus_a.in_ready, busy_a, bus_a.load);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt = 2'd0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_c(8'(8'h10 + i));
      repeat (3) @(negedge clk);
      exp_cnt = (exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1;
      tests_run++;
      if (cnt_c !== exp_cnt) begin
        tests_failed++; $display("FAIL sat_load_cnt_%0d load_cnt=%0d required=%0d", i, cnt_c, exp_cnt);
      end
    end
    tests_run++;
    if (err_c !== 1'b0) begin
      tests_failed++; $display("FAIL sat_err err=%b required=0", err_c);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0;
    bus_c.in_valid = 1'b0; bus_c.in_data = '0;
    force_a = 1'b0; force_val_a = '0;
    test_reset();
    test_single_word();
    test_back_to_back_gap2();
    test_mismatch();
    test_reset_mid_op();
    test_saturation();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
